// File: rtl/fb_scanout_if.sv
// Image-memory read port plus display-side valid/ready pixel stream of the frame-buffer reader.
// The master modport is the scanout engine; the slave modport is the memory/sink side.
interface fb_scanout_if;
    logic [19:0] IM_A;
    logic [23:0] IM_Q;
    logic        IM_WEN;
    logic [23:0] pix_data;
    logic        pix_valid;
    logic        pix_ready;
    logic        pix_sof;
    logic        pix_eol;

    modport master (
        output IM_A, IM_WEN, pix_data, pix_valid, pix_sof, pix_eol,
        input  IM_Q, pix_ready
    );

    modport slave (
        input  IM_A, IM_WEN, pix_data, pix_valid, pix_sof, pix_eol,
        output IM_Q, pix_ready
    );
endinterface

// File: rtl/fb_scanout.sv
// Frame-buffer scanout: fetches the frame base from the IM header word, then streams W*H
// RGB888 pixels from image memory through a small first-word-fall-through FIFO to the sink.
module fb_scanout #(
    parameter int          W          = 256,
    parameter int          H          = 256,
    parameter int          FIFO_DEPTH = 4,
    parameter logic [19:0] HDR_ADDR   = 20'd0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    output logic         busy,
    output logic         done,
    fb_scanout_if.master bus
);
    localparam int NPIX = W * H;
    localparam int IW   = $clog2(NPIX + 1);
    localparam int CW   = (W > 1) ? $clog2(W) : 1;
    localparam int PW   = $clog2(FIFO_DEPTH);
    localparam int KW   = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [1:0] {IDLE, HDR_REQ, HDR_WAIT, STREAM} state_t;

    state_t        state_q, state_d;
    logic [19:0]   fbBase_q, fbBase_d;
    logic [IW-1:0] rdIdx_q, rdIdx_d;
    logic [CW-1:0] col_q, col_d;
    logic          inflight_q;
    logic          inflightSof_q, inflightEol_q;
    logic [19:0]   imA_q, imA_d;
    logic          done_q, done_d;
    logic [25:0]   fifoMem_q [FIFO_DEPTH];
    logic [PW-1:0] wrPtr_q, rdPtr_q;
    logic [KW-1:0] count_q;

    logic          issue, canIssue, push, pop, issueSof, issueEol;
    logic [25:0]   head;

    // Occupancy counts the read in flight so a full FIFO can never be overrun by late data.
    assign canIssue = (rdIdx_q < IW'(NPIX)) && ((int'(count_q) + int'(inflight_q)) < FIFO_DEPTH);
    assign push     = inflight_q;
    assign pop      = (count_q != '0) && bus.pix_ready;
    assign issueSof = (rdIdx_q == '0);
    assign issueEol = (col_q == CW'(W - 1));

    always_comb begin
        state_d  = state_q;
        fbBase_d = fbBase_q;
        rdIdx_d  = rdIdx_q;
        col_d    = col_q;
        imA_d    = imA_q;
        done_d   = 1'b0;
        issue    = 1'b0;
        unique case (state_q)
            IDLE: begin
                imA_d = '0;
                if (start) begin
                    state_d = HDR_REQ;
                    rdIdx_d = '0;
                    col_d   = '0;
                end
            end
            HDR_REQ: begin
                imA_d   = HDR_ADDR;
                state_d = HDR_WAIT;
            end
            HDR_WAIT: begin
                fbBase_d = bus.IM_Q[19:0];
                state_d  = STREAM;
            end
            STREAM: begin
                issue = canIssue;
                if (issue) begin
                    imA_d   = fbBase_q + 20'(rdIdx_q);
                    rdIdx_d = rdIdx_q + 1'b1;
                    col_d   = issueEol ? '0 : col_q + 1'b1;
                end
                // The final handshake is the only pop left once everything is issued and landed.
                if (rdIdx_q == IW'(NPIX) && !inflight_q && count_q == KW'(1) && pop) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            fbBase_q      <= '0;
            rdIdx_q       <= '0;
            col_q         <= '0;
            inflight_q    <= 1'b0;
            inflightSof_q <= 1'b0;
            inflightEol_q <= 1'b0;
            imA_q         <= '0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            fbBase_q      <= fbBase_d;
            rdIdx_q       <= rdIdx_d;
            col_q         <= col_d;
            inflight_q    <= issue;
            inflightSof_q <= issue & issueSof;
            inflightEol_q <= issue & issueEol;
            imA_q         <= imA_d;
            done_q        <= done_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) fifoMem_q[i] <= '0;
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                fifoMem_q[wrPtr_q] <= {inflightSof_q, inflightEol_q, bus.IM_Q};
                wrPtr_q            <= wrPtr_q + 1'b1;
            end
            if (pop) rdPtr_q <= rdPtr_q + 1'b1;
            if (push && !pop)      count_q <= count_q + 1'b1;
            else if (!push && pop) count_q <= count_q - 1'b1;
        end
    end

    assign head          = fifoMem_q[rdPtr_q];
    assign bus.pix_valid = (count_q != '0);
    assign bus.pix_data  = bus.pix_valid ? head[23:0] : '0;
    assign bus.pix_eol   = bus.pix_valid & head[24];
    assign bus.pix_sof   = bus.pix_valid & head[25];
    assign bus.IM_A      = imA_d;
    assign bus.IM_WEN    = 1'b1;
    assign busy          = (state_q != IDLE);
    assign done          = done_q;
endmodule
